// File: rtl/tank_arena_store.sv
// tank_arena_store: grid arena state for NUM_TANKS tanks, each owning one
// projectile, with a sequential command port and an external synchronous
// wall-map RAM.
//
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_op/id/dir/addr    MOVE, FIRE, STEP (projectile), READ (cell word)
//   wall_addr/wall_rd_data  registered wall lookup, data sampled one cycle later
//   rsp_valid/status/pos/data  one-cycle response, 3 cycles after accept
//   hit_valid/hit_id      projectile strike report, pulses with rsp_valid
//   tank_pos_flat, proj_active  live arena state
//
// Response fields: rsp_pos/rsp_data give the affected object's position and
// direction after the command (tank for MOVE, projectile for FIRE/STEP).
// BADID responds with rsp_pos/rsp_data zero. READ ignores cmd_id.
module tank_arena_store #(
  parameter int NUM_TANKS  = 2,
  parameter int COORD_BITS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [1:0]                        cmd_id,
  input  logic [1:0]                        cmd_dir,
  input  logic [2*COORD_BITS-1:0]           cmd_addr,
  output logic [2*COORD_BITS-1:0]           wall_addr,
  input  logic                              wall_rd_data,
  output logic                              rsp_valid,
  output logic [2:0]                        rsp_status,
  output logic [2*COORD_BITS-1:0]           rsp_pos,
  output logic [NUM_TANKS+3:0]              rsp_data,
  output logic                              hit_valid,
  output logic [1:0]                        hit_id,
  output logic [NUM_TANKS*2*COORD_BITS-1:0] tank_pos_flat,
  output logic [NUM_TANKS-1:0]              proj_active
);

  localparam int P      = 2 * COORD_BITS;
  localparam int CELL_W = NUM_TANKS + 4;
  localparam logic [COORD_BITS-1:0] CMAX = '1;
  localparam logic [COORD_BITS-1:0] CONE = COORD_BITS'(1);

  typedef enum logic [1:0] {IDLE, CALC, CHECK, RESP} state_t;
  typedef enum logic [1:0] {OP_MOVE, OP_FIRE, OP_STEP, OP_READ} op_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [2:0] {ST_OK, ST_EDGE, ST_WALL, ST_TANK, ST_BUSY,
                            ST_HIT, ST_INACTIVE, ST_BADID} status_t;

  function automatic logic [P-1:0] home_pos(input int unsigned i);
    case (i)
      0:       home_pos = '0;
      1:       home_pos = '1;
      2:       home_pos = {{COORD_BITS{1'b0}}, CMAX};
      default: home_pos = {CMAX, {COORD_BITS{1'b0}}};
    endcase
  endfunction

  function automatic logic [1:0] home_dir(input int unsigned i);
    home_dir = (i % 2 == 0) ? DIR_DOWN : DIR_UP;
  endfunction

  state_t           state;
  logic [1:0]       op_q, id_q, dir_q;
  logic [P-1:0]     addr_q, cand_q;
  logic             edge_q;

  logic [P-1:0]     tank_pos [NUM_TANKS];
  logic [1:0]       tank_dir [NUM_TANKS];
  logic [P-1:0]     proj_pos [NUM_TANKS];
  logic [1:0]       proj_dir [NUM_TANKS];

  // Selected object and one-cell step of the latched command.
  logic [P-1:0]          sel_tpos, sel_ppos, src_pos, cand;
  logic [1:0]            sel_tdir, sel_pdir, step_dir;
  logic                  sel_pact, id_ok, at_edge;
  logic [COORD_BITS-1:0] row, col;

  always_comb begin
    sel_tpos = '0;
    sel_ppos = '0;
    sel_tdir = '0;
    sel_pdir = '0;
    sel_pact = 1'b0;
    for (int unsigned i = 0; i < NUM_TANKS; i++) begin
      if (id_q == 2'(i)) begin
        sel_tpos = tank_pos[i];
        sel_tdir = tank_dir[i];
        sel_ppos = proj_pos[i];
        sel_pdir = proj_dir[i];
        sel_pact = proj_active[i];
      end
    end
    id_ok = int'(id_q) < NUM_TANKS;
    case (op_q)
      OP_FIRE: begin src_pos = sel_tpos; step_dir = sel_tdir; end
      OP_STEP: begin src_pos = sel_ppos; step_dir = sel_pdir; end
      default: begin src_pos = sel_tpos; step_dir = dir_q;    end
    endcase
    row     = src_pos[P-1:COORD_BITS];
    col     = src_pos[COORD_BITS-1:0];
    cand    = src_pos;
    at_edge = 1'b0;
    // On an edge step cand stays at the source, which is what wall_addr shows.
    case (step_dir)
      DIR_UP:    if (row == '0)  at_edge = 1'b1; else cand = {row - CONE, col};
      DIR_DOWN:  if (row == CMAX) at_edge = 1'b1; else cand = {row + CONE, col};
      DIR_LEFT:  if (col == '0)  at_edge = 1'b1; else cand = {row, col - CONE};
      default:   if (col == CMAX) at_edge = 1'b1; else cand = {row, col + CONE};
    endcase
  end

  // Occupancy of the candidate cell and of the READ cell, plus the decision.
  logic                 other_occ, cell_proj;
  logic [1:0]           hit_lo, cell_dir;
  logic [NUM_TANKS-1:0] cell_tanks;
  status_t              dec_status;

  always_comb begin
    other_occ  = 1'b0;
    hit_lo     = '0;
    cell_tanks = '0;
    cell_proj  = 1'b0;
    cell_dir   = '0;
    for (int unsigned i = 0; i < NUM_TANKS; i++) begin
      if (tank_pos[i] == cand_q && id_q != 2'(i) && !other_occ) begin
        other_occ = 1'b1;
        hit_lo    = 2'(i);
      end
      if (tank_pos[i] == addr_q) cell_tanks[i] = 1'b1;
      if (proj_active[i] && proj_pos[i] == addr_q) cell_proj = 1'b1;
    end
    // Descending scan so the lowest-index tank present wins.
    for (int unsigned i = NUM_TANKS; i > 0; i--) begin
      if (cell_tanks[i-1]) cell_dir = tank_dir[i-1];
    end

    dec_status = ST_OK;
    if (op_q != OP_READ) begin
      if (!id_ok)                         dec_status = ST_BADID;
      else if (op_q == OP_FIRE && sel_pact)  dec_status = ST_BUSY;
      else if (op_q == OP_STEP && !sel_pact) dec_status = ST_INACTIVE;
      else if (edge_q)                    dec_status = ST_EDGE;
      else if (wall_rd_data)              dec_status = ST_WALL;
      else if (other_occ)                 dec_status = (op_q == OP_MOVE) ? ST_TANK : ST_HIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      hit_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_pos     <= '0;
      rsp_data    <= '0;
      hit_id      <= '0;
      wall_addr   <= '0;
      op_q        <= '0;
      id_q        <= '0;
      dir_q       <= '0;
      addr_q      <= '0;
      cand_q      <= '0;
      edge_q      <= 1'b0;
      proj_active <= '0;
      for (int unsigned i = 0; i < NUM_TANKS; i++) begin
        tank_pos[i] <= home_pos(i);
        tank_dir[i] <= home_dir(i);
        proj_pos[i] <= home_pos(i);
        proj_dir[i] <= home_dir(i);
      end
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q      <= cmd_op;
          id_q      <= cmd_id;
          dir_q     <= cmd_dir;
          addr_q    <= cmd_addr;
          cmd_ready <= 1'b0;
          state     <= CALC;
        end
        CALC: begin
          cand_q    <= cand;
          edge_q    <= at_edge;
          wall_addr <= (op_q == OP_READ) ? addr_q : cand;
          state     <= CHECK;
        end
        CHECK: begin
          rsp_valid  <= 1'b1;
          rsp_status <= dec_status;
          hit_valid  <= (dec_status == ST_HIT);
          hit_id     <= (dec_status == ST_HIT) ? hit_lo : '0;
          rsp_pos    <= '0;
          rsp_data   <= '0;
          case (op_q)
            OP_READ: begin
              rsp_pos  <= addr_q;
              rsp_data <= {wall_rd_data, cell_tanks, cell_proj, cell_dir};
            end
            OP_MOVE: if (id_ok) begin
              rsp_pos  <= (dec_status == ST_OK) ? cand_q : sel_tpos;
              rsp_data <= CELL_W'(dir_q);
              for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                if (id_q == 2'(i)) begin
                  tank_dir[i] <= dir_q;
                  if (dec_status == ST_OK) tank_pos[i] <= cand_q;
                end
              end
            end
            OP_FIRE: if (id_ok) begin
              rsp_pos  <= (dec_status == ST_OK) ? cand_q : sel_ppos;
              rsp_data <= CELL_W'((dec_status == ST_OK) ? sel_tdir : sel_pdir);
              for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                if (id_q == 2'(i) && dec_status == ST_OK) begin
                  proj_active[i] <= 1'b1;
                  proj_pos[i]    <= cand_q;
                  proj_dir[i]    <= sel_tdir;
                end
              end
            end
            default: if (id_ok) begin
              rsp_pos  <= (dec_status == ST_OK) ? cand_q : sel_ppos;
              rsp_data <= CELL_W'(sel_pdir);
              for (int unsigned i = 0; i < NUM_TANKS; i++) begin
                if (id_q == 2'(i)) begin
                  if (dec_status == ST_OK) proj_pos[i] <= cand_q;
                  else if (dec_status != ST_INACTIVE) proj_active[i] <= 1'b0;
                end
              end
            end
          endcase
          state <= RESP;
        end
        default: begin
          rsp_valid <= 1'b0;
          hit_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    tank_pos_flat = '0;
    for (int unsigned i = 0; i < NUM_TANKS; i++) tank_pos_flat[i*P +: P] = tank_pos[i];
  end

endmodule

// File: tb/tb_tank_arena_store.sv
module tb_tank_arena_store;
  localparam int NT = 2;
  localparam int CB = 4;

  logic       clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, wall_rd_data = 1'b0;
  logic [1:0] cmd_op = '0, cmd_id = '0, cmd_dir = '0;
  logic [7:0] cmd_addr = '0;
  logic       cmd_ready, rsp_valid, hit_valid;
  logic [7:0] wall_addr, rsp_pos;
  logic [2:0] rsp_status;
  logic [5:0] rsp_data;
  logic [1:0] hit_id;
  logic [15:0] tank_pos_flat;
  logic [1:0] proj_active;

  always #5 clk = ~clk;

  tank_arena_store #(.NUM_TANKS(NT), .COORD_BITS(CB)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_dir(cmd_dir), .cmd_addr(cmd_addr),
    .wall_addr(wall_addr), .wall_rd_data(wall_rd_data), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_pos(rsp_pos), .rsp_data(rsp_data),
    .hit_valid(hit_valid), .hit_id(hit_id), .tank_pos_flat(tank_pos_flat),
    .proj_active(proj_active)
  );

  // Wall map RAM: data for the current wall_addr is ready by the next edge.
  bit walls [256];
  always @(negedge clk) wall_rd_data = walls[wall_addr];

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural arena model: row/col integers per object.
  int tr[4], tc[4], td[4], pr[4], pc[4], pd[4];
  bit pa[4];

  typedef struct {
    int status; int pos; int data; bit hit; int hid; int waddr;
    logic [15:0] tflat; logic [1:0] pact; int acc;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model_home();
    tr[0] = 0;  tc[0] = 0;  td[0] = 1;
    tr[1] = 15; tc[1] = 15; td[1] = 0;
    for (int i = 0; i < NT; i++) begin
      pr[i] = tr[i]; pc[i] = tc[i]; pd[i] = td[i]; pa[i] = 0;
    end
  endfunction

  task automatic model_cmd(input int op, input int id, input int dir, input int addr, output exp_t e);
    int r, c, lo, sr, sc, sd, nr, nc, hit;
    bit off, wl, anyp;
    e = '{default: 0};
    if (op == 3) begin
      r = addr / 16; c = addr % 16; lo = -1; anyp = 0;
      e.status = 0; e.pos = addr; e.waddr = addr;
      e.data = walls[addr] ? 32 : 0;
      for (int i = 0; i < NT; i++) begin
        if (tr[i] == r && tc[i] == c) begin
          e.data += 1 << (3 + i);
          if (lo < 0) lo = i;
        end
        if (pa[i] && pr[i] == r && pc[i] == c) anyp = 1;
      end
      if (anyp) e.data += 4;
      if (lo >= 0) e.data += td[lo];
    end else if (id >= NT) begin
      e.status = 7;
    end else begin
      if (op == 0)      begin sr = tr[id]; sc = tc[id]; sd = dir;    end
      else if (op == 1) begin sr = tr[id]; sc = tc[id]; sd = td[id]; end
      else              begin sr = pr[id]; sc = pc[id]; sd = pd[id]; end
      nr = sr + ((sd == 1) ? 1 : 0) - ((sd == 0) ? 1 : 0);
      nc = sc + ((sd == 3) ? 1 : 0) - ((sd == 2) ? 1 : 0);
      off = (nr < 0 || nr > 15 || nc < 0 || nc > 15);
      e.waddr = off ? sr * 16 + sc : nr * 16 + nc;
      wl = !off && walls[nr * 16 + nc];
      hit = -1;
      for (int j = 0; j < NT; j++)
        if (j != id && tr[j] == nr && tc[j] == nc && hit < 0) hit = j;
      if (op == 1 && pa[id])       e.status = 4;
      else if (op == 2 && !pa[id]) e.status = 6;
      else if (off)                e.status = 1;
      else if (wl)                 e.status = 2;
      else if (hit >= 0)           e.status = (op == 0) ? 3 : 5;
      else                         e.status = 0;
      if (op == 0) begin
        td[id] = dir;
        if (e.status == 0) begin tr[id] = nr; tc[id] = nc; end
        e.pos = tr[id] * 16 + tc[id]; e.data = dir;
      end else if (op == 1) begin
        if (e.status == 0) begin pa[id] = 1; pr[id] = nr; pc[id] = nc; pd[id] = td[id]; end
        e.pos = pr[id] * 16 + pc[id]; e.data = pd[id];
      end else begin
        if (e.status == 0) begin pr[id] = nr; pc[id] = nc; end
        else if (e.status != 6) pa[id] = 0;
        e.pos = pr[id] * 16 + pc[id]; e.data = pd[id];
      end
      e.hit = (e.status == 5);
      e.hid = hit;
    end
    e.tflat = '0;
    for (int i = 0; i < NT; i++) begin
      e.tflat[i*8 +: 8] = 8'(tr[i] * 16 + tc[i]);
      e.pact[i] = pa[i];
    end
  endtask

  // Compare process: every negedge, responses against the model's queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("latency", pcnt, e.acc + 3);
          chk("status", rsp_status, e.status);
          if (e.status != 7) begin
            chk("rsp_pos", rsp_pos, e.pos);
            chk("rsp_data", rsp_data, e.data);
            chk("wall_addr", wall_addr, e.waddr);
          end
          chk("hit_valid", hit_valid, e.hit);
          if (e.hit) chk("hit_id", hit_id, e.hid);
          chk("tank_pos_flat", tank_pos_flat, e.tflat);
          chk("proj_active", proj_active, e.pact);
        end
      end else begin
        chk("hit_idle", hit_valid, 0);
      end
    end
  end

  task automatic do_cmd(input int op, input int id, input int dir, input int addr, output exp_t e);
    int n;
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    model_cmd(op, id, dir, addr, e);
    e.acc = pcnt;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_id = 2'(id); cmd_dir = 2'(dir); cmd_addr = 8'(addr);
    @(negedge clk);
    chk("ready_busy", cmd_ready, 0);
    n = 1;
    while (!rsp_valid && n < 12) begin
      // Noise on the command port while busy must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 2'($urandom); cmd_id = 2'($urandom); cmd_dir = 2'($urandom); cmd_addr = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout actual=none required=rsp_valid (t=%0t)", $time);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; cmd_valid = 1'b0;
    model_home();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int op, id, dir, addr, sel;
    model_home();
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_status", rsp_status, 0);
    chk("rst_pos", rsp_pos, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_hit_id", hit_id, 0);
    chk("rst_wall_addr", wall_addr, 0);
    chk("rst_tank_pos", tank_pos_flat, 16'hFF00);
    chk("rst_proj", proj_active, 0);
    reset = 1'b1;
    @(negedge clk);

    do_cmd(3, 0, 0, 8'h00, e);
    chk("pin_read_data", e.data, 6'b001001);
    do_cmd(0, 0, 0, 0, e);
    chk("pin_edge_status", e.status, 1);
    chk("edge_pos_hold", tank_pos_flat[7:0], 8'h00);
    walls[1] = 1;
    do_cmd(0, 0, 3, 0, e);
    chk("pin_wall_status", e.status, 2);
    chk("pin_wall_addr", e.waddr, 8'h01);
    chk("pin_wall_dir", e.data, 3);
    walls[1] = 0;
    do_cmd(0, 3, 0, 0, e);
    chk("pin_badid", e.status, 7);

    do_reset();
    do_cmd(1, 0, 0, 0, e);
    chk("pin_fire_pos", e.pos, 8'h10);
    chk("fire_active", proj_active[0], 1);
    do_cmd(1, 0, 0, 0, e);
    chk("pin_fire_busy", e.status, 4);

    do_reset();
    repeat (15) do_cmd(0, 1, 2, 0, e);
    chk("pin_tank1_pos", e.pos, 8'hF0);
    do_cmd(1, 0, 0, 0, e);
    repeat (13) do_cmd(2, 0, 0, 0, e);
    chk("pin_step13_pos", e.pos, 8'hE0);
    do_cmd(2, 0, 0, 0, e);
    chk("pin_hit_status", e.status, 5);
    chk("pin_hit_id", e.hid, 1);
    chk("hit_deactivated", proj_active[0], 0);

    // Reset while a command sits in CHECK: no response, home state.
    do_reset();
    do_cmd(1, 0, 0, 0, e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = 2'd1; cmd_dir = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_home();
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_wall_addr", wall_addr, 0);
    chk("midrst_proj", proj_active, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", cmd_ready, 1);
    chk("midrst_tank_pos", tank_pos_flat, 16'hFF00);
    repeat (4) @(negedge clk);

    // Randomized traffic over a random wall map.
    do_reset();
    for (int a = 0; a < 256; a++)
      walls[a] = ($urandom_range(0, 99) < 12) && a != 0 && a != 255;
    for (int k = 0; k < 400; k++) begin
      op  = $urandom_range(0, 3);
      id  = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      dir = $urandom_range(0, 3);
      sel = $urandom_range(0, 2);
      if (sel == 0)      addr = $urandom_range(0, 255);
      else if (sel == 1) addr = tr[k % NT] * 16 + tc[k % NT];
      else               addr = pr[k % NT] * 16 + pc[k % NT];
      do_cmd(op, id, dir, addr, e);
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tank_arena_store.md
TANK_ARENA_STORE -- requirements
Module: tank_arena_store

Interface
REQ-001 SHALL have parameter NUM_TANKS, default 2, number of tanks and projectiles, legal range 2..4.
REQ-002 SHALL have parameter COORD_BITS, default 4, bits per grid coordinate; the grid is 2^COORD_BITS x 2^COORD_BITS.
REQ-003 SHALL define P = 2*COORD_BITS (position width, pos = {row, col}) and CELL_W = NUM_TANKS+4.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  command accept; a command is taken on a clk edge where cmd_valid && cmd_ready.
REQ-008 cmd_op  input  2  00 MOVE, 01 FIRE, 10 STEP (projectile), 11 READ (cell).
REQ-009 cmd_id  input  2  tank/projectile index.
REQ-010 cmd_dir  input  2  00 up, 01 down, 10 left, 11 right (MOVE only).
REQ-011 cmd_addr  input  P  cell position (READ only).
REQ-012 wall_addr  output  P  registered wall-map lookup address.
REQ-013 wall_rd_data  input  1  wall bit for wall_addr, valid one cycle after wall_addr changes (synchronous RAM).
REQ-014 rsp_valid  output  1  one-cycle response strobe.
REQ-015 rsp_status  output  3  0 OK, 1 EDGE, 2 WALL, 3 TANK, 4 BUSY, 5 HIT, 6 INACTIVE, 7 BADID.
REQ-016 rsp_pos  output  P  resulting position (READ: cmd_addr).
REQ-017 rsp_data  output  CELL_W  READ: cell word; other ops: resulting direction, zero-extended.
REQ-018 hit_valid  output  1  pulses with rsp_valid when status is HIT; hit_id  output  2  index of tank struck.
REQ-019 tank_pos_flat  output  NUM_TANKS*P  tank i at bits [i*P +: P]; proj_active  output  NUM_TANKS  projectile active flags.

Function
REQ-020 FSM states IDLE, CALC, CHECK, RESP; cmd_ready = 1 only in IDLE.
REQ-021 Accept at edge T -> CALC; CALC registers the candidate position and drives it on wall_addr -> CHECK at T+1; CHECK samples wall_rd_data, decides and updates state -> RESP at T+2; rsp_valid = 1 during RESP -> IDLE at T+3.
REQ-022 Candidate = source stepped one cell: up row-1, down row+1, left col-1, right col+1; a step leaving the grid is EDGE, and wall_addr then holds the source position (wall result ignored); no wrap-around.
REQ-023 Decision priority: BADID > BUSY/INACTIVE > EDGE > WALL > TANK/HIT > OK.
REQ-024 cmd_id >= NUM_TANKS: status BADID, no state change, same latency.
REQ-025 MOVE: tank direction always becomes cmd_dir; position updates to candidate only if status is OK; candidate occupied by any other tank is TANK.
REQ-026 FIRE: projectile already active is BUSY; otherwise candidate = tank position stepped by tank direction; EDGE/WALL leave the projectile inactive; another tank there is HIT (projectile stays inactive); OK activates the projectile at the candidate with the tank's direction.
REQ-027 STEP: inactive projectile is INACTIVE; EDGE/WALL deactivate it; a non-owner tank at the candidate is HIT and deactivates it; otherwise it moves, status OK.
REQ-028 On HIT, hit_id = lowest index of the tank struck.
REQ-029 READ cell word: bit CELL_W-1 wall, bits [NUM_TANKS+2:3] tank-present flags (tank i at bit 3+i), bit 2 any active projectile present, [1:0] direction of the lowest-index tank present, else 00.
REQ-030 Tank positions never coincide; active projectiles never occupy a wall cell.

Reset
REQ-031 Reset low forces IDLE immediately, whatever the current state: cmd_ready 1; rsp_valid, hit_valid, rsp_status, rsp_pos, rsp_data, hit_id, wall_addr 0; proj_active all 0.
REQ-032 Reset positions/directions: tank0 {0,0} down; tank1 {max,max} up; tank2 {0,max} down; tank3 {max,0} up; projectile positions equal their tank positions, with directions equal to the tank directions.
REQ-033 An in-flight command is discarded by reset and produces no response.

Verification (NUM_TANKS=2, COORD_BITS=4)
REQ-034 Reset, READ 0x00, wall_rd_data=0 -> rsp_valid at T+2 edge-to-strobe, status 0, rsp_data 6'b001001.
REQ-035 MOVE id0 up after reset -> status 1, rsp_pos 0x00, rsp_data 0; tank_pos_flat[7:0] stays 0x00.
REQ-036 MOVE id0 right, wall_rd_data=1 in CHECK -> wall_addr 0x01, status 2, position 0x00, direction 11.
REQ-037 FIRE id0 (dir down, wall clear) -> status 0, rsp_pos 0x10, proj_active[0]=1; second FIRE id0 -> status 4.
REQ-038 MOVE id1 left x15 (to 0xF0), FIRE id0 down, STEP id0 x13 (reaches 0xE0), 14th STEP -> status 5, hit_valid=1, hit_id=1, proj_active[0]=0.
REQ-039 Reset asserted while in CHECK -> no rsp_valid; cmd_ready 1 the cycle after release; state matches REQ-032.
